// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmitter. Bytes are popped one at a time and
// issued with the transmitter's start/ready handshake.
module uart_tx_feeder #(
  parameter int AW  = 4,
  parameter int GAP = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  input  logic        clr_ovf,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        overflow,
  output logic        busy
);
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;

  logic [7:0]    mem [DEPTH];
  logic          wr_accept;
  logic          wr_drop;
  logic          pop;

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != S_IDLE) || !empty;

  // A flush swallows any same-cycle write without flagging it as dropped.
  assign wr_accept = wr_en && !full && !flush;
  assign wr_drop   = wr_en && full && !flush;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    gap_cnt_d  = gap_cnt_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && tx_ready && !flush) begin
          pop        = 1'b1;
          tx_data_d  = mem[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Ready dropping is the transmitter's acknowledge of start.
        if (!tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (tx_ready) begin
          if (GAP > 0) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // A drop in the same cycle as a clear wins so the event is not lost.
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte queue and handshake sequencer that sits directly upstream of the serial transmitter, between the J1 SoC peripheral write path and the UART TX block.
- Buffers bytes written by the CPU in a FIFO.
- Pops bytes one at a time and presents each to the transmitter using its start/data/ready handshake.
- Holds start until the transmitter acknowledges by dropping ready, then waits for ready to return high before issuing the next byte.

Parameters:
- AW, 4, FIFO address width; depth = 2**AW entries (16).
- GAP, 0, idle clock cycles inserted between the end of one byte (ready high again) and the next issue; 0 = back-to-back.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous reset, active-low; all state cleared
- wr_en  in  1  push wr_data into FIFO this cycle
- wr_data  in  8  byte to queue
- flush  in  1  synchronous FIFO clear
- clr_ovf  in  1  clears overflow flag
- tx_ready  in  1  transmitter idle/ready indication
- tx_start  out  1  start request to transmitter (registered)
- tx_data  out  8  byte to transmitter (registered, stable while tx_start=1)
- full  out  1  FIFO holds 2**AW entries
- empty  out  1  FIFO holds 0 entries
- level  out  AW+1  number of queued bytes (excludes the byte in flight)
- overflow  out  1  sticky: a write was dropped
- busy  out  1  high when FIFO is non-empty or FSM is not in IDLE

Behaviour:
- Reset (asynchronous, rstn=0): pointers=0, level=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, busy=0, FSM=IDLE, gap counter=0.
- FIFO: circular buffer, read/write pointers AW bits each, plus an AW+1 bit count. Pointers wrap modulo 2**AW.
- full = (level == 2**AW). empty = (level == 0). Both derived from the registered count.
- Write with wr_en=1 and full=0: store at wr_ptr, increment wr_ptr.
- Write with wr_en=1 and full=1: byte dropped and overflow set. This holds even when a pop occurs in the same cycle.
- Simultaneous accepted write and pop: level unchanged, both pointers advance.
- flush=1: pointers and level go to 0 at the next edge. Any wr_en in the same cycle is ignored and does not set overflow. A byte already in flight (tx_data) is not aborted.
- Overflow: clr_ovf clears it. If clr_ovf and a dropped write coincide, the flag stays set.
- FSM states:
  - IDLE: if empty=0 and tx_ready=1, load tx_data from the FIFO head, pop (rd_ptr+1, level-1), set tx_start=1, go ISSUE.
  - ISSUE: hold tx_start=1 and tx_data. When tx_ready=0 is sampled, clear tx_start and go BUSY. Waits indefinitely. The transmitter registers start, so ready stays high for about 2 cycles after start rises.
  - BUSY: when tx_ready=1 is sampled, go GAP if GAP>0 (load counter GAP-1), else go IDLE.
  - GAP: decrement counter; at 0, go IDLE.
- Latency: a write captured at edge E0 into an empty FIFO, with the FSM in IDLE and tx_ready=1, gives tx_start=1 and tx_data valid after edge E1.
- tx_start is never high in BUSY or GAP. This prevents a re-trigger when the transmitter returns to idle.
- busy = (state != IDLE) or (empty == 0).
- Reset mid-operation clears tx_start immediately. Queued and in-flight bytes are lost.
- GAP counter width: clog2(GAP+1), minimum 1 bit.

Test Plan:
- Reset release, write 8'h41 once, tx_ready=1 → tx_start=1 and tx_data=8'h41 one cycle after the write edge. Model ready low 2 cycles later → tx_start=0 next cycle. Level returns to 0.
- Write 8'h01..8'h10 back-to-back (16 bytes) with tx_ready held low → full=1, level=16. A 17th write (8'hFF) → overflow=1, byte absent from the output stream. Release ready with the transmitter model → bytes 01..10 emitted in order, no duplicates.
- GAP=5, two bytes queued → exactly 5 cycles between tx_ready rising after byte 1 and tx_start rising for byte 2. With GAP=0 → tx_start rises on the edge after ready is observed high.
- While byte 8'hA5 is in ISSUE and 3 bytes are queued, pulse flush together with wr_en (8'h77) → A5 completes, level=0, 8'h77 never sent, overflow stays 0.
- Assert rstn=0 asynchronously during ISSUE → tx_start drops without a clock edge. After release: empty=1, busy=0, no further tx_start.
- Wrap-around: push and pop 40 bytes with the FIFO never empty → output order matches input order across pointer wrap; level never exceeds 16.
